// File: rtl/audio_i2s_capture_if.sv
// audio_i2s_capture_if
// Sample stream between the I2S capture block and its consumer.
//   st_data    : captured sample, two's complement (FIFO head)
//   st_channel : 0 = left, 1 = right
//   st_valid   : FIFO non-empty
//   st_ready   : consumer takes the head when st_valid & st_ready
// master = capture block (source), slave = consumer (sink).
`timescale 1ns/1ps
interface audio_i2s_capture_if #(
  parameter int unsigned SAMPLE_WIDTH = 16
);
  logic [SAMPLE_WIDTH-1:0] st_data;
  logic                    st_channel;
  logic                    st_valid;
  logic                    st_ready;

  modport master (
    output st_data,
    output st_channel,
    output st_valid,
    input  st_ready
  );

  modport slave (
    input  st_data,
    input  st_channel,
    input  st_valid,
    output st_ready
  );
endinterface

// File: rtl/audio_i2s_capture.sv
// audio_i2s_capture
// Deserialises codec ADC audio (I2S or left-justified) into a FIFO and
// presents it as a valid/ready sample stream.
//
// Ports:
//   clk_clk, reset_reset_n : system clock (>= 4x BCLK), async active-low reset
//   enable                 : capture enable
//   adc_bclk/lrck/dat      : codec pins, asynchronous (LRCK low = left)
//   st                     : sample stream (audio_i2s_capture_if.master)
//   fifo_count             : occupied FIFO entries, 0..DEPTH
//   overflow, overflow_clr : sticky word-dropped flag and its clear (set wins)
//   short_err              : 1-cycle pulse, slot ended before SAMPLE_WIDTH bits
//   peak_level, peak_clr   : peak |sample| since clear, and its clear
//
// Optional feature: define AUDIO_PEAK_DETECT_EN to build the peak detector;
// otherwise peak_level is tied to 0 and peak_clr is ignored.
//
// Slot timing: the BCLK rise at which an LRCK change is first seen starts the
// slot; the MSB is taken on the 2nd following rise (I2S_DELAY=1) or the 1st
// following rise (I2S_DELAY=0).
`timescale 1ns/1ps
module audio_i2s_capture #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned I2S_DELAY    = 1
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       enable,
  input  logic                       adc_bclk,
  input  logic                       adc_lrck,
  input  logic                       adc_dat,
  audio_i2s_capture_if.master        st,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic                       short_err,
  output logic [SAMPLE_WIDTH-1:0]    peak_level,
  input  logic                       peak_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SHIFT,
    S_WAIT
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronisers and BCLK rise / LRCK edge detection
  // ---------------------------------------------------------------
  logic bclk_meta, bclk_sync, bclk_dly;
  logic lrck_meta, lrck_sync, lrck_prev;
  logic dat_meta, dat_sync;
  logic bclk_rise, lrck_edge;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_dly  <= 1'b0;
      lrck_meta <= 1'b0;
      lrck_sync <= 1'b0;
      dat_meta  <= 1'b0;
      dat_sync  <= 1'b0;
    end else begin
      bclk_meta <= adc_bclk;
      bclk_sync <= bclk_meta;
      bclk_dly  <= bclk_sync;
      lrck_meta <= adc_lrck;
      lrck_sync <= lrck_meta;
      dat_meta  <= adc_dat;
      dat_sync  <= dat_meta;
    end
  end

  assign bclk_rise = bclk_sync & ~bclk_dly;
  assign lrck_edge = bclk_rise & (lrck_sync != lrck_prev);

  // LRCK level is only tracked at BCLK rises, independent of enable, so a
  // capture can start on the first edge after enable goes high.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lrck_prev <= 1'b0;
    end else if (bclk_rise) begin
      lrck_prev <= lrck_sync;
    end
  end

  // ---------------------------------------------------------------
  // Slot FSM and shift register
  // ---------------------------------------------------------------
  state_t                  state, state_next;
  logic [SAMPLE_WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_next;
  logic                    chan, chan_next;
  logic                    push_req, push_req_next;
  logic [SAMPLE_WIDTH-1:0] push_data, push_data_next;
  logic                    push_chan, push_chan_next;
  logic                    short_next;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      chan      <= 1'b0;
      push_req  <= 1'b0;
      push_data <= '0;
      push_chan <= 1'b0;
      short_err <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;
      chan      <= chan_next;
      push_req  <= push_req_next;
      push_data <= push_data_next;
      push_chan <= push_chan_next;
      short_err <= short_next;
    end
  end

  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt;
    chan_next      = chan;
    push_req_next  = 1'b0;
    push_data_next = push_data;
    push_chan_next = push_chan;
    short_next     = 1'b0;

    if (!enable) begin
      state_next   = S_IDLE;
      shift_next   = '0;
      bit_cnt_next = '0;
    end else if (bclk_rise) begin
      if (lrck_edge) begin
        // A new slot always restarts capture; only an interrupted shift is
        // reported as a short frame.
        short_next   = (state == S_SHIFT);
        chan_next    = lrck_sync;
        shift_next   = '0;
        bit_cnt_next = '0;
        state_next   = (I2S_DELAY != 0) ? S_DELAY : S_SHIFT;
      end else begin
        unique case (state)
          S_DELAY: state_next = S_SHIFT;
          S_SHIFT: begin
            shift_next = {shift_reg[SAMPLE_WIDTH-2:0], dat_sync};
            if (bit_cnt == CNT_W'(SAMPLE_WIDTH - 1)) begin
              bit_cnt_next   = '0;
              state_next     = S_WAIT;
              push_req_next  = !chan || (CHANNELS == 2);
              push_data_next = {shift_reg[SAMPLE_WIDTH-2:0], dat_sync};
              push_chan_next = chan;
            end else begin
              bit_cnt_next = bit_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------
  logic [SAMPLE_WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [PTR_W:0]          count;
  logic [SAMPLE_WIDTH-1:0] hold_data;
  logic                    hold_chan;
  logic                    full, empty, pop, wr_en;
  logic [SAMPLE_WIDTH:0]   head;

  assign full  = (count == (PTR_W + 1)'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && st.st_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign wr_en = push_req && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {push_chan, push_data};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_chan <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_data <= head[SAMPLE_WIDTH-1:0];
        hold_chan <= head[SAMPLE_WIDTH];
      end
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push_req && !wr_en) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Empty FIFO shows the last word handed out rather than stale memory.
  assign st.st_valid   = !empty;
  assign st.st_data    = empty ? hold_data : head[SAMPLE_WIDTH-1:0];
  assign st.st_channel = empty ? hold_chan : head[SAMPLE_WIDTH];
  assign fifo_count    = count;

  // ---------------------------------------------------------------
  // Peak detector
  // ---------------------------------------------------------------
`ifdef AUDIO_PEAK_DETECT_EN
  localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [SAMPLE_WIDTH-1:0] MOST_POS = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};

  logic [SAMPLE_WIDTH-1:0] mag;

  always_comb begin
    mag = push_data;
    if (push_data[SAMPLE_WIDTH-1]) begin
      mag = (push_data == MOST_NEG) ? MOST_POS : ('0 - push_data);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      peak_level <= '0;
    end else if (wr_en) begin
      if (peak_clr || (mag > peak_level)) begin
        peak_level <= mag;
      end
    end else if (peak_clr) begin
      peak_level <= '0;
    end
  end
`else
  logic peak_clr_unused;
  assign peak_clr_unused = peak_clr;
  assign peak_level      = '0;
`endif

endmodule
